// File: rtl/rf_multiport_sync_pkg.sv
// Shared constants for the register file and the writeback stage:
// writeback-source encodings, the PC increment, and address-width sizing.
package rf_pkg;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   localparam int PC_INC = 4;

   // Smallest width that can address 'depth' entries.
   function automatic int rf_aw(input int depth);
      int w;
      w = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) < depth) begin
            w = k + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/rf_multiport_sync_wb_mux.sv
// Writeback-source selector: ALU result, load data, PC+4 or immediate.
// Purely combinational so the pipelined WB stage can reuse it unchanged.
module rf_wb_mux
   import rf_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]    wb_sel_i,
   input  logic [DW-1:0] alu_res_i,
   input  logic [DW-1:0] mem_data_i,
   input  logic [DW-1:0] pc_i,
   input  logic [DW-1:0] imm_i,
   output logic [DW-1:0] wdata_o
);

   // PC+4 wraps at DW bits.
   always_comb begin
      wdata_o = alu_res_i;
      case (wb_sel_i)
         WB_ALU:  wdata_o = alu_res_i;
         WB_MEM:  wdata_o = mem_data_i;
         WB_PC4:  wdata_o = pc_i + DW'(PC_INC);
         WB_IMM:  wdata_o = imm_i;
         default: wdata_o = alu_res_i;
      endcase
   end

endmodule

// File: rtl/rf_multiport_sync.sv
// Parametrised register file: two write ports (port 0 via the writeback mux),
// NUM_RD registered read ports with optional write-first bypass.
module rf_multiport_sync
   import rf_pkg::*;
#(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = rf_aw(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD-1:0]    rd_en,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_valid,
   input  logic                 wr0_en,
   input  logic [AW-1:0]        wr0_addr,
   input  logic [1:0]           wb_sel,
   input  logic [DW-1:0]        alu_res,
   input  logic [DW-1:0]        mem_data,
   input  logic [DW-1:0]        pc,
   input  logic [DW-1:0]        imm,
   input  logic                 wr1_en,
   input  logic [AW-1:0]        wr1_addr,
   input  logic [DW-1:0]        wr1_data
);

   logic [DW-1:0]        mem_q [DEPTH];
   logic [DW-1:0]        wdata0_s;
   logic [(1<<AW)-1:0]   addr_ok_s;
   logic                 wr0_commit_s;
   logic                 wr1_commit_s;

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return ZERO_REG && (a == {AW{1'b0}});
   endfunction

   rf_wb_mux #(.DW(DW)) u_wb_mux (
      .wb_sel_i   (wb_sel),
      .alu_res_i  (alu_res),
      .mem_data_i (mem_data),
      .pc_i       (pc),
      .imm_i      (imm),
      .wdata_o    (wdata0_s)
   );

   // Lookup of implemented addresses; codes >= DEPTH exist only for non-power-of-2 depths.
   for (genvar k = 0; k < (1 << AW); k++) begin : g_addr_ok
      assign addr_ok_s[k] = (k < DEPTH) ? 1'b1 : 1'b0;
   end

   // Port 1 wins a same-address collision, so port 0 backs off entirely.
   always_comb begin
      wr1_commit_s = wr1_en & addr_ok_s[wr1_addr] & ~is_zero_reg(wr1_addr);
      wr0_commit_s = wr0_en & addr_ok_s[wr0_addr] & ~is_zero_reg(wr0_addr)
                     & ~(wr1_en & (wr1_addr == wr0_addr));
   end

   // Storage array update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= {DW{1'b0}};
         end
      end else begin
         if (wr0_commit_s) begin
            mem_q[wr0_addr] <= wdata0_s;
         end
         if (wr1_commit_s) begin
            mem_q[wr1_addr] <= wr1_data;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] addr_s;
      logic [DW-1:0] data_d;
      logic [DW-1:0] data_q;
      logic          valid_q;

      assign addr_s = rd_addr[i*AW +: AW];

      // Read value selection; a disabled port keeps its last data.
      always_comb begin
         data_d = data_q;
         if (!rd_en[i]) begin
            data_d = data_q;
         end else if (!addr_ok_s[addr_s] || is_zero_reg(addr_s)) begin
            data_d = {DW{1'b0}};
         end else if (BYPASS && wr1_commit_s && (wr1_addr == addr_s)) begin
            data_d = wr1_data;
         end else if (BYPASS && wr0_commit_s && (wr0_addr == addr_s)) begin
            data_d = wdata0_s;
         end else begin
            data_d = mem_q[addr_s];
         end
      end

      // Registered read data and its one-cycle valid pulse.
      always_ff @(posedge clk) begin
         if (rst) begin
            data_q  <= {DW{1'b0}};
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= rd_en[i];
         end
      end

      assign rd_data[i*DW +: DW] = data_q;
      assign rd_valid[i]         = valid_q;
   end

endmodule

// File: tb/tb_rf_multiport_sync.sv
// Drives two register-file configurations from one stimulus stream and checks
// both against an array model of architectural state.
module tb_rf_multiport_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rd_en;
   logic [14:0] rd_addr;
   logic        wr0_en;
   logic [4:0]  wr0_addr;
   logic [1:0]  wb_sel;
   logic [31:0] alu_res, mem_data, pc, imm;
   logic        wr1_en;
   logic [4:0]  wr1_addr;
   logic [31:0] wr1_data;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_valid;
   logic [95:0] b_rd_data;
   logic [2:0]  b_rd_valid;

   int errors = 0;
   int checks = 0;

   int unsigned depth_m [2] = '{32, 24};
   bit          zreg_m  [2] = '{1'b1, 1'b0};
   bit          byp_m   [2] = '{1'b1, 1'b0};
   int          nrd_m   [2] = '{2, 3};
   logic [31:0] mem_m   [2][32];
   logic [31:0] exp_d   [2][3];
   logic        exp_v   [2][3];

   always #5 clk = ~clk;

   rf_multiport_sync u_a (
      .clk(clk), .rst(rst), .rd_en(rd_en[1:0]), .rd_addr(rd_addr[9:0]),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wb_sel(wb_sel), .alu_res(alu_res),
      .mem_data(mem_data), .pc(pc), .imm(imm),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data)
   );

   rf_multiport_sync #(.DW(32), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wb_sel(wb_sel), .alu_res(alu_res),
      .mem_data(mem_data), .pc(pc), .imm(imm),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic bit writable(input int m, input int a);
      return (a < int'(depth_m[m])) && !(zreg_m[m] && a == 0);
   endfunction

   // Architectural view: state after the edge is old state with port 0 then port 1 applied.
   task automatic model_edge();
      logic [31:0] wd0;
      logic [31:0] after [32];
      int          a;
      case (wb_sel)
         2'd0:    wd0 = alu_res;
         2'd1:    wd0 = mem_data;
         2'd2:    wd0 = pc + 32'd4;
         default: wd0 = imm;
      endcase
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int k = 0; k < 32; k++) mem_m[m][k] = 32'd0;
            for (int i = 0; i < 3; i++) begin
               exp_d[m][i] = 32'd0;
               exp_v[m][i] = 1'b0;
            end
         end else begin
            after = mem_m[m];
            if (wr0_en && writable(m, int'(wr0_addr))) after[wr0_addr] = wd0;
            if (wr1_en && writable(m, int'(wr1_addr))) after[wr1_addr] = wr1_data;
            for (int i = 0; i < nrd_m[m]; i++) begin
               exp_v[m][i] = rd_en[i];
               if (rd_en[i]) begin
                  a = int'(rd_addr[i*5 +: 5]);
                  exp_d[m][i] = byp_m[m] ? after[a] : mem_m[m][a];
               end
            end
            mem_m[m] = after;
         end
      end
   endtask

   task automatic tick();
      logic [31:0] obs_d;
      logic        obs_v;
      model_edge();
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < nrd_m[m]; i++) begin
            if (m == 0) begin
               obs_d = a_rd_data[i*32 +: 32];
               obs_v = a_rd_valid[i];
            end else begin
               obs_d = b_rd_data[i*32 +: 32];
               obs_v = b_rd_valid[i];
            end
            check32($sformatf("dut%0d_rdata_p%0d", m, i), obs_d, exp_d[m][i]);
            check32($sformatf("dut%0d_rvalid_p%0d", m, i), {31'd0, obs_v}, {31'd0, exp_v[m][i]});
         end
      end
   endtask

   task automatic idle();
      rst = 1'b0; rd_en = 3'b000; wr0_en = 1'b0; wr1_en = 1'b0;
   endtask

   initial begin
      idle();
      rd_addr = 15'd0; wr0_addr = 5'd0; wr1_addr = 5'd0; wb_sel = 2'b00;
      alu_res = 32'd0; mem_data = 32'd0; pc = 32'd0; imm = 32'd0; wr1_data = 32'd0;
      rst = 1'b1;
      tick();

      // Reset clears stored data
      idle(); wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'hDEADBEEF; tick();
      idle(); rst = 1'b1; tick();
      idle(); rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd5}; tick();
      check32("reset_r5", a_rd_data[31:0], 32'h0);
      check32("reset_r5_valid", {31'd0, a_rd_valid[0]}, 32'd1);

      // Writeback mux: PC+4, IMM, PC+4 wrap
      idle(); wr0_en = 1'b1; wr0_addr = 5'd3; wb_sel = 2'b10; pc = 32'h0000_0100; tick();
      idle(); rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd3}; tick();
      check32("pc4", a_rd_data[31:0], 32'h0000_0104);
      idle(); wr0_en = 1'b1; wr0_addr = 5'd4; wb_sel = 2'b11; imm = 32'h1234_5000; tick();
      idle(); rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd4}; tick();
      check32("imm", a_rd_data[31:0], 32'h1234_5000);
      idle(); wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 32'h5555_5555; tick();
      idle(); wr0_en = 1'b1; wr0_addr = 5'd6; wb_sel = 2'b10; pc = 32'hFFFF_FFFC; tick();
      idle(); rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd6}; tick();
      check32("pc4_wrap", a_rd_data[31:0], 32'h0);

      // Zero register on both ports
      idle(); wr0_en = 1'b1; wr0_addr = 5'd0; wb_sel = 2'b00; alu_res = 32'hFFFF_FFFF;
      wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF; tick();
      idle(); rd_en = 3'b111; rd_addr = 15'd0; tick();
      check32("zero_reg_on", a_rd_data[31:0], 32'h0);
      check32("zero_reg_off", b_rd_data[31:0], 32'hFFFF_FFFF);

      // Collision, bypass vs read-old
      idle(); wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h99; tick();
      idle(); wr0_en = 1'b1; wr0_addr = 5'd7; wb_sel = 2'b00; alu_res = 32'h11;
      wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
      rd_en = 3'b010; rd_addr = {5'd0, 5'd7, 5'd0}; tick();
      check32("bypass_collide", a_rd_data[63:32], 32'h22);
      check32("readold_collide", b_rd_data[63:32], 32'h99);
      idle(); rd_en = 3'b010; rd_addr = {5'd0, 5'd7, 5'd0}; tick();
      check32("collide_after_a", a_rd_data[63:32], 32'h22);
      check32("collide_after_b", b_rd_data[63:32], 32'h22);

      // Multi-port read and hold
      idle(); wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hA5A5_A5A5; tick();
      idle(); rd_en = 3'b111; rd_addr = {5'd9, 5'd9, 5'd9}; tick();
      check32("multi_p2", b_rd_data[95:64], 32'hA5A5_A5A5);
      idle(); wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h5A;
      rd_en = 3'b011; rd_addr = {5'd9, 5'd9, 5'd9}; tick();
      check32("hold_p2", b_rd_data[95:64], 32'hA5A5_A5A5);
      check32("hold_p2_valid", {31'd0, b_rd_valid[2]}, 32'd0);

      // Addresses beyond a non-power-of-2 depth
      idle(); wr1_en = 1'b1; wr1_addr = 5'd30; wr1_data = 32'h3030_3030; tick();
      idle(); rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd30}; tick();
      check32("oob_r30", b_rd_data[31:0], 32'h0);
      idle(); wr1_en = 1'b1; wr1_addr = 5'd23; wr1_data = 32'h2323_2323; tick();
      idle(); rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd23}; tick();
      check32("last_r23", b_rd_data[31:0], 32'h2323_2323);

      // Randomised traffic with biased address collisions
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 59) == 0);
         rd_en    = 3'($urandom);
         wr0_en   = 1'($urandom);
         wr1_en   = 1'($urandom);
         wr0_addr = 5'($urandom);
         wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom);
         wb_sel   = 2'($urandom);
         alu_res  = $urandom; mem_data = $urandom; pc = $urandom; imm = $urandom;
         wr1_data = $urandom;
         rd_addr  = 15'($urandom);
         if ($urandom_range(0, 2) == 0) rd_addr[4:0] = wr1_addr;
         if ($urandom_range(0, 2) == 0) rd_addr[9:5] = wr0_addr;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_multiport_sync.md
Name: rf_multiport_sync

Overview:
- Parametrised successor to the single-cycle core's 32x32 register file.
- Generalised data width, depth and read-port count.
- Two write ports and a built-in writeback-source mux (ALU / MEM / PC+4 / IMM).
- Registered, single-clock-edge reads with optional write-first bypass, so it serves both the single-cycle and the planned pipelined datapaths.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of architectural registers; must be ≥2.
- NUM_RD, 2, number of read ports; range 1..4.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero: writes ignored, reads return 0.
- BYPASS, 1, 1 = write-first forwarding to same-cycle reads; 0 = read-old.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- rd_en  input  NUM_RD  per-port read enable.
- rd_addr  input  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  output  NUM_RD*DW  registered read data; port i occupies [i*DW +: DW].
- rd_valid  output  NUM_RD  1-cycle pulse marking new rd_data.
- wr0_en  input  1  write port 0 enable (writeback port).
- wr0_addr  input  AW  write port 0 address.
- wb_sel  input  2  port 0 source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- alu_res  input  DW  ALU result.
- mem_data  input  DW  load data.
- pc  input  DW  current PC; +4 is added internally.
- imm  input  DW  immediate (LUI path).
- wr1_en  input  1  write port 1 enable (raw data).
- wr1_addr  input  AW  write port 1 address.
- wr1_data  input  DW  write port 1 data.

Behaviour:
- Reset: rst=1 sampled at posedge clears all DEPTH entries to 0 and sets rd_data=0 and rd_valid=0 in that same edge. Reset dominates any write or read presented in that cycle.
- Port 0 write data:
  - wdata0 = mux(wb_sel) of alu_res, mem_data, pc+4, imm.
  - pc+4 truncates to DW bits, so pc=FFFFFFFC gives 00000000.
- Write commit:
  - Port w commits at posedge when wr_en=1, addr<DEPTH, and !(ZERO_REG && addr==0).
  - An address ≥ DEPTH (non-power-of-2 DEPTH) is silently dropped.
- Write collision: both ports enabled to the same address → port 1 wins; port 0 write discarded.
- Read latency: rd_en[i]=1 at edge N → rd_data[i] and rd_valid[i]=1 visible after edge N. rd_en[i]=0 → rd_data[i] holds its previous value and rd_valid[i]=0.
- Read value, in priority order:
  1. 0 if ZERO_REG and addr==0, or if addr ≥ DEPTH.
  2. If BYPASS=1 and the same edge commits a write to that address: the winning write data (port 1 over port 0).
  3. Otherwise the stored entry before the edge.
- Read ports are independent; all NUM_RD ports may target the same address.
- ZERO_REG=0: entry 0 is an ordinary register.
- No internal FSM beyond the storage array; rd_valid is the only handshake. Consumers must not assume rd_data is valid without rd_valid.

Decomposition:
- Package rf_pkg holds:
  - wb_sel localparams WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_IMM=2'b11;
  - PC_INC=4;
  - a function computing AW from DEPTH.
- One sub-module, rf_wb_mux: the combinational 4:1 writeback-source mux producing wdata0, reusable by the pipeline's WB stage.
- Read-port logic is a generate loop over NUM_RD, not a separate module.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5, assert rst one cycle, then read r5 on port 0 → rd_data=0, rd_valid=1 one cycle after rd_en.
- Writeback mux and latency:
  - wb_sel=10, pc=0x00000100, write r3; next cycle read r3 → 0x00000104.
  - wb_sel=11, imm=0x12345000 → 0x12345000.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0 on both ports → r0 reads 0. Repeat with ZERO_REG=0 → reads 0xFFFFFFFF.
- Collision and bypass:
  - Same edge: wr0 r7=0x11 (ALU), wr1 r7=0x22, read r7 on port 1. BYPASS=1 → 0x22 immediately and 0x22 next cycle.
  - Old r7=0x99 with BYPASS=0 → 0x99 first, then 0x22.
- Multi-port and hold: NUM_RD=3, all ports read r9=0xA5A5A5A5 → all three return it. Drop rd_en[2] while r9 is rewritten to 0x5A → port 2 holds 0xA5A5A5A5 with rd_valid[2]=0.
- Non-power-of-2 depth: DEPTH=24 (AW=5), write to r30 and read r30 → rd_data=0. r23 remains writable and readable.
